// File: rtl/ethsim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ethsim_pkg : shared AXI-Stream widths and arbiter state type   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package ethsim_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  localparam int GRANT_W     = 3;
  localparam int GAP_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_picker : rotating-priority encoder, first request at/after  |
// | ptr (wrapping). Rev 1.0                                        |
// +----------------------------------------------------------------+
module rr_picker
  import ethsim_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  // Scanning from the farthest offset down lets the nearest requester win last.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int off = N_PORTS - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_PORTS]) begin
        idx = GRANT_W'((int'(ptr) + off) % N_PORTS);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | eth_tx_arbiter : frame-granular round-robin AXI-Stream mux     |
// | with programmable inter-frame gap. Rev 1.0                     |
// +----------------------------------------------------------------+
module eth_tx_arbiter
  import ethsim_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int IFG_CYCLES = 2
) (
  input  logic                           clk156,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             s_tvalid,
  output logic [N_PORTS-1:0]             s_tready,
  input  logic [AXIS_DATA_W*N_PORTS-1:0] s_tdata,
  input  logic [AXIS_KEEP_W*N_PORTS-1:0] s_tkeep,
  input  logic [N_PORTS-1:0]             s_tlast,
  input  logic [N_PORTS-1:0]             s_tuser,
  input  logic                           m_tready,
  output logic                           m_tvalid,
  output logic [AXIS_DATA_W-1:0]         m_tdata,
  output logic [AXIS_KEEP_W-1:0]         m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tuser,
  output logic [GRANT_W-1:0]             grant,
  output logic [31:0]                    frame_cnt
);

  localparam logic [GAP_W-1:0]   GAP_LOAD  = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  localparam logic [GRANT_W-1:0] LAST_PORT = GRANT_W'(N_PORTS - 1);

  arb_state_t         state_q,     state_d;
  logic [GRANT_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [GRANT_W-1:0] grant_q,     grant_d;
  logic [GAP_W-1:0]   gap_q,       gap_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;
  logic               beat_xfer;

  rr_picker #(
    .N_PORTS (N_PORTS)
  ) u_picker (
    .req   (s_tvalid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Data path is a pure mux gated by the registered state, so a reset
  // clears every output in the same cycle it is asserted.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    s_tready = '0;
    if (state_q == BUSY) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant_q == GRANT_W'(i)) begin
          m_tvalid    = s_tvalid[i];
          m_tdata     = s_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
          m_tkeep     = s_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W];
          m_tlast     = s_tlast[i];
          m_tuser     = s_tuser[i];
          s_tready[i] = m_tready;
        end
      end
    end
  end

  assign beat_xfer = m_tvalid && m_tready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (beat_xfer && m_tlast) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          if (IFG_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_eth_tx_arbiter : randomized self-checking bench with a      |
// | frame-level reference model. Rev 1.0                           |
// +----------------------------------------------------------------+
module tb_eth_tx_arbiter;

  localparam int N   = 4;
  localparam int IFG = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic          clk156 = 1'b0;
  logic          rst;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast, s_tuser;
  logic [64*N-1:0] s_tdata;
  logic [8*N-1:0]  s_tkeep;
  logic          m_tready, m_tvalid, m_tlast, m_tuser;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [2:0]    grant;
  logic [31:0]   frame_cnt;

  eth_tx_arbiter #(
    .N_PORTS    (N),
    .IFG_CYCLES (IFG)
  ) dut (
    .clk156    (clk156),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .m_tready  (m_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .grant     (grant),
    .frame_cnt (frame_cnt)
  );

  always #5 clk156 = ~clk156;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source-side stimulus queues and the expected per-source frame streams.
  beat_t       pend [N][$];
  beat_t       expq [N][$];
  logic [N-1:0] presenting = '0;
  logic [N-1:0] acc        = '0;

  // Frame-level reference: which source owns the port, rotating pointer,
  // earliest cycle a new arbitration may happen, completed frame count.
  int          cyc = 0;
  int          idle_from = 0;
  int          last_tlast = -100;
  int          last_spacing = 0;
  bit          mi_frame = 0;
  bit          first_beat = 0;
  bit          chk_cnt = 0;
  bit          chk_grant = 0;
  int          mg = 0;
  int          mptr = 0;
  int          mbeats = 0;
  logic [31:0] mframes = '0;
  int          sent [N];

  bit          rand_valid = 0;
  int          ready_mode = 0;
  bit          rdy_pat [$];

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic bit busy();
    bit b = mi_frame || chk_cnt || chk_grant;
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() != 0 || expq[i].size() != 0) b = 1;
    end
    return b;
  endfunction

  task automatic add_frame(input int src, input int len, input logic [7:0] lkeep, input logic usr);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = (k == len - 1) ? lkeep : 8'hFF;
      b.last = (k == len - 1);
      b.user = (k == len - 1) ? usr : 1'b0;
      pend[src].push_back(b);
      expq[src].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t cur;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(pend[i].pop_front());
        presenting[i] = 1'b0;
      end
      if (!presenting[i] && pend[i].size() > 0 && (!rand_valid || $urandom_range(3) != 0))
        presenting[i] = 1'b1;
      cur = presenting[i] ? pend[i][0] : '0;
      s_tvalid[i]          = presenting[i];
      s_tdata[i*64 +: 64]  = cur.data;
      s_tkeep[i*8 +: 8]    = cur.keep;
      s_tlast[i]           = cur.last;
      s_tuser[i]           = cur.user;
    end
    acc = '0;
    case (ready_mode)
      1:       m_tready = 1'($urandom_range(1));
      2:       m_tready = (mi_frame && rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic step();
    beat_t        eb;
    logic [N-1:0] exp_rdy;
    @(negedge clk156);
    cyc++;
    drive();
    #1;
    if (chk_cnt) begin
      check("frame_cnt", 96'(frame_cnt), 96'(mframes));
      chk_cnt = 0;
    end
    if (chk_grant) begin
      check("grant", 96'(grant), 96'(mg));
      chk_grant = 0;
    end
    if (mi_frame) begin
      exp_rdy = '0;
      exp_rdy[mg] = m_tready;
      check("s_tready", 96'(s_tready), 96'(exp_rdy));
      check("m_tvalid", 96'(m_tvalid), 96'(s_tvalid[mg]));
      if (m_tvalid) begin
        check("exp_avail", 96'(expq[mg].size() > 0), 96'(1));
        if (expq[mg].size() > 0) begin
          eb = expq[mg][0];
          check("beat", 96'({m_tdata, m_tkeep, m_tlast, m_tuser}), 96'(eb));
          if (first_beat) begin
            last_spacing = cyc - last_tlast;
            first_beat   = 0;
          end
          if (m_tready) begin
            void'(expq[mg].pop_front());
            mbeats++;
            if (eb.last) begin
              mi_frame   = 0;
              mframes    = mframes + 32'd1;
              chk_cnt    = 1;
              sent[mg]++;
              last_tlast = cyc;
              idle_from  = cyc + 1 + IFG;
            end
          end
        end
      end
    end else begin
      check("idle_out", 96'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, s_tready}), 96'(0));
      if (cyc >= idle_from && s_tvalid != '0) begin
        mg         = pick(s_tvalid, mptr);
        mptr       = (mg + 1) % N;
        mi_frame   = 1;
        first_beat = 1;
        mbeats     = 0;
        chk_grant  = 1;
      end
    end
    acc = s_tvalid & s_tready;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (busy() && k < budget) begin
      step();
      k++;
    end
    check(tag, 96'(busy()), 96'(0));
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      expq[i].delete();
    end
    presenting = '0;
    acc        = '0;
    s_tvalid   = '0;
    mi_frame   = 0;
    chk_cnt    = 0;
    chk_grant  = 0;
    mptr       = 0;
    mframes    = '0;
    idle_from  = cyc;
    last_tlast = -100;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int snap [N];
    int k;
    rst = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    repeat (3) @(negedge clk156);
    #1;
    check("rst_outputs", 96'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, s_tready}), 96'(0));
    check("rst_grant", 96'(grant), 96'(0));
    check("rst_frame_cnt", 96'(frame_cnt), 96'(0));
    check("rst_rr_ptr", 96'(dut.rr_ptr_q), 96'(0));
    @(negedge clk156);
    rst = 1'b0;

    // Lone source 2, short last beat.
    add_frame(2, 3, 8'h0F, 1'b0);
    drain("t1_drain", 50);
    check("t1_grant", 96'(grant), 96'(2));
    check("t1_frame_cnt", 96'(frame_cnt), 96'(1));

    // Sources 0 and 1 request together.
    add_frame(0, 2, 8'hFF, 1'b0);
    add_frame(1, 2, 8'h3F, 1'b1);
    drain("t2_drain", 60);
    check("t2_spacing", 96'(last_spacing), 96'(IFG + 2));
    check("t2_grant", 96'(grant), 96'(1));
    check("t2_frame_cnt", 96'(frame_cnt), 96'(3));

    // All sources busy: two frames each.
    for (int i = 0; i < N; i++) snap[i] = sent[i];
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        add_frame(i, 1 + $urandom_range(3), 8'(1 + $urandom_range(254)), 1'($urandom_range(1)));
    drain("t3_drain", 200);
    for (int i = 0; i < N; i++) check("t3_per_source", 96'(sent[i] - snap[i]), 96'(2));

    // Backpressure 1,0,0,1 on a 4-beat frame while another source waits.
    ready_mode = 2;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    add_frame(mptr, 4, 8'hFF, 1'b0);
    add_frame((mptr + 2) % N, 2, 8'h01, 1'b0);
    drain("t4_drain", 80);
    ready_mode = 0;

    // Randomized traffic with ready and valid bubbles.
    ready_mode = 1;
    rand_valid = 1;
    for (int f = 0; f < 30; f++)
      add_frame($urandom_range(N - 1), 1 + $urandom_range(5),
                8'(1 + $urandom_range(254)), 1'($urandom_range(1)));
    drain("rand_drain", 4000);
    ready_mode = 0;
    rand_valid = 0;

    // Reset while beat 2 of a 4-beat frame is on the bus.
    add_frame(2, 4, 8'hFF, 1'b0);
    k = 0;
    while (!(mi_frame && mbeats == 2) && k < 20) begin
      step();
      k++;
    end
    check("t5_reach_beat2", 96'(mbeats), 96'(2));
    check("t5_pre_valid", 96'(m_tvalid), 96'(1));
    #2 rst = 1'b1;
    #1;
    check("t5_m_tvalid", 96'(m_tvalid), 96'(0));
    check("t5_frame_cnt", 96'(frame_cnt), 96'(0));
    check("t5_rr_ptr", 96'(dut.rr_ptr_q), 96'(0));
    clear_model();
    repeat (2) @(negedge clk156);
    rst = 1'b0;
    add_frame(3, 2, 8'hFF, 1'b0);
    add_frame(0, 2, 8'hFF, 1'b0);
    step();
    check("t5_tie_winner", 96'(mg), 96'(0));
    drain("t5_drain", 60);

    // Counter wrap.
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.frame_cnt_q;
    mframes = 32'hFFFF_FFFF;
    step();
    check("t6_preset", 96'(frame_cnt), 96'(32'hFFFF_FFFF));
    add_frame(1, 2, 8'hFF, 1'b0);
    drain("t6_drain", 40);
    check("t6_wrap", 96'(frame_cnt), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
